dsec_out_sequencer: RTL and testbench
=====================================

# dsec_out_sequencer

Output-side sequencer for the data stream compression/encryption (DSEC) path. It sits between the shift-concatenation stage and the external receiving device. It buffers completed 64-bit words and runs the out_valid/out_rcvd handshake. It also sequences end-of-stream flushes (dump_comp to the compressor, then wait for the residual word, then drain) and holds the upstream modules in stall during key configuration, flush and buffer-full conditions.

## Interface
- DEPTH, 4, output buffer entries (power of two, ≥2)
- DATA_W, 64, word width
- BITS_W, 7, width of valid-bit count (0..64)
- FLUSH_TIMEOUT, 16, cycles to wait for the residual word after dump_comp
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- key_config  in  1  encryption keys being configured
- end_stream  in  1  single-cycle request to flush residual compressed data
- scon_done  in  1  scon_data/scon_bits valid this cycle
- scon_data  in  DATA_W  word from shift-concatenation
- scon_bits  in  BITS_W  valid bits in scon_data (64 = full word)
- out_rcvd  in  1  receiver accepts out_data at this edge
- out_valid  out  1  out_data/out_bits/out_last valid
- out_data  out  DATA_W  head-of-buffer word
- out_bits  out  BITS_W  valid bits of head word
- out_last  out  1  head word is the final word of a flushed stream
- dump_comp  out  1  one-cycle command to the compressor to emit remaining data
- stall  out  1  upstream must hold state
- flush_done  out  1  one-cycle pulse: flush sequence complete
- overflow  out  1  sticky: a scon word was dropped because the buffer was full

## Operation
- Buffer: FIFO of {data, bits, last}, DEPTH entries. scon_done pushes. The push is accepted if not full, or if full and a pop occurs in the same cycle. Otherwise the word is dropped and overflow is set (cleared only by rst).
- Output: out_valid = !empty. The out_* signals show the head entry and stay stable until popped. A pop occurs at an edge where out_valid & out_rcvd. out_rcvd while !out_valid is ignored.
- FSM states:
  - RUN (reset state):
    - key_config=1 -> KEYCFG.
    - Else end_stream=1 -> FLUSH.
    - Pushes are tagged last=0.
  - KEYCFG:
    - Return to RUN when key_config=0.
    - end_stream is ignored.
    - The buffer keeps draining.
  - FLUSH: dump_comp=1 for exactly this cycle. Load the timeout counter with FLUSH_TIMEOUT. -> FWAIT.
  - FWAIT:
    - scon_done with scon_bits>0: push the word with last=1, -> DRAIN.
    - scon_done with scon_bits=0: no push, -> DRAIN.
    - Otherwise decrement the counter. At 0, -> DRAIN with no last word.
  - DRAIN: when the buffer is empty, pulse flush_done and go -> RUN.
- key_config and end_stream are ignored in FLUSH/FWAIT/DRAIN. end_stream is ignored in KEYCFG.
- stall = (state != RUN) | full | key_config (combinational).
- scon_done outside FWAIT always pushes with last=0. This includes KEYCFG, FLUSH and DRAIN.

## Timing
- Reset values: out_valid=0, out_data=0, out_bits=0, out_last=0, dump_comp=0, stall=0, flush_done=0, overflow=0. The FIFO is emptied and the state is RUN.
- rst mid-flush or mid-handshake: abandon everything and return to reset values on the next edge.
- Push-to-output latency: scon_done sampled at edge N into an empty buffer gives out_valid=1 in the cycle after N.
- Pop: out_rcvd at edge N makes the next entry (or out_valid=0) visible after N.
- Full buffer with simultaneous push and pop: both occur, count unchanged, no overflow.
- Empty buffer with simultaneous push and pop: not possible (pop needs out_valid).
- end_stream at edge N (RUN):
  - FLUSH in cycle N+1 (dump_comp high).
  - FWAIT from N+2.
  - On timeout, DRAIN is entered after FLUSH_TIMEOUT FWAIT cycles.
- flush_done is high for one cycle: the cycle in DRAIN when the buffer is empty. The state is RUN on the following edge.
- key_config and end_stream in the same RUN cycle: key_config wins, and end_stream is lost.

## Structure
- Package dsec_pkg:
  - state enum (RUN, KEYCFG, FLUSH, FWAIT, DRAIN)
  - DATA_W and BITS_W constants
  - FIFO entry struct {data, bits, last}
- Sub-module dsec_word_fifo: parameterised synchronous FIFO with push/pop, full/empty and count, and same-cycle push+pop when full.
- The top level holds the FSM, the timeout counter, the stall/overflow logic and the output mapping.

## Test plan
- Reset, then push 3 words (0xA1.., 0xA2.., 0xA3.., bits=64) with out_rcvd held 1 -> three out_valid cycles, in order, each one cycle after its push; out_last=0.
- Push 5 words into DEPTH=4 with out_rcvd=0 -> stall=1 after the 4th push, 5th word dropped, overflow=1; drain the buffer -> exactly 4 words out, overflow stays 1.
- Full buffer, same-cycle push and out_rcvd -> no overflow, count stays 4, order preserved.
- end_stream, then scon_done with bits=23 two cycles after dump_comp -> dump_comp high one cycle, word out with out_bits=23 and out_last=1, flush_done one cycle after it is popped.
- end_stream with no scon_done -> DRAIN after 16 FWAIT cycles, flush_done when the buffer is empty, no out_last word.
- key_config=1 for 5 cycles while 2 words are buffered -> stall=1 throughout, both words still delivered, end_stream during KEYCFG ignored (no dump_comp); rst asserted in FWAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dsec_pkg.sv
// rtl/dsec_pkg.sv - shared types and constants for the DSEC output sequencer
package dsec_pkg;

  localparam int DATA_W = 64;
  localparam int BITS_W = 7;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_KEYCFG,
    ST_FLUSH,
    ST_FWAIT,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BITS_W-1:0] bits;
    logic              last;
  } fifo_entry_t;

endpackage

// File: rtl/dsec_word_fifo.sv
// rtl/dsec_word_fifo.sv - synchronous word FIFO; a push into a full FIFO is taken when a pop shares the edge
module dsec_word_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count decide what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dsec_out_sequencer.sv
// rtl/dsec_out_sequencer.sv - output buffer, receiver handshake and end-of-stream flush sequencing
module dsec_out_sequencer #(
  parameter int DEPTH         = 4,
  parameter int DATA_W        = dsec_pkg::DATA_W,
  parameter int BITS_W        = dsec_pkg::BITS_W,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_config,
  input  logic              end_stream,
  input  logic              scon_done,
  input  logic [DATA_W-1:0] scon_data,
  input  logic [BITS_W-1:0] scon_bits,
  input  logic              out_rcvd,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [BITS_W-1:0] out_bits,
  output logic              out_last,
  output logic              dump_comp,
  output logic              stall,
  output logic              flush_done,
  output logic              overflow
);

  import dsec_pkg::*;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BITS_W-1:0] bits;
    logic              last;
  } entry_t;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(FLUSH_TIMEOUT);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          overflow_q, overflow_d;

  entry_t        push_entry, head;
  logic          push_req, pop, in_fwait;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign in_fwait = (state_q == ST_FWAIT);
  // A zero-bit residual word ends the wait but is never buffered.
  assign push_req   = scon_done & ~(in_fwait & (scon_bits == '0));
  assign push_entry = '{data: scon_data, bits: scon_bits, last: in_fwait};
  assign pop        = out_rcvd & ~fifo_empty;
  assign overflow_d = overflow_q | (push_req & ~pop & (fifo_count == FULL_CNT));

  dsec_word_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    dump_comp  = 1'b0;
    flush_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (key_config)      state_d = ST_KEYCFG;
        else if (end_stream) state_d = ST_FLUSH;
      end
      ST_KEYCFG: begin
        if (!key_config) state_d = ST_RUN;
      end
      ST_FLUSH: begin
        dump_comp = 1'b1;
        timer_d   = TIMEOUT_LOAD;
        state_d   = ST_FWAIT;
      end
      ST_FWAIT: begin
        if (scon_done) begin
          state_d = ST_DRAIN;
        end else begin
          timer_d = timer_q - 1'b1;
          if (timer_q == TW'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          flush_done = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      timer_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_empty ? '0 : head.data;
  assign out_bits  = fifo_empty ? '0 : head.bits;
  assign out_last  = ~fifo_empty & head.last;
  assign stall     = (state_q != ST_RUN) | fifo_full | key_config;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_dsec_out_sequencer.sv
// tb/tb_dsec_out_sequencer.sv - self-checking bench for dsec_out_sequencer
module tb_dsec_out_sequencer;
  import dsec_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int M_RUN = 0, M_KEY = 1, M_FLUSH = 2, M_WAIT = 3, M_DRAIN = 4;

  logic        clk = 1'b0;
  logic        rst, key_config, end_stream, scon_done, out_rcvd;
  logic [63:0] scon_data;
  logic [6:0]  scon_bits;
  logic        out_valid, out_last, dump_comp, stall, flush_done, overflow;
  logic [63:0] out_data;
  logic [6:0]  out_bits;

  always #5 clk = ~clk;

  dsec_out_sequencer #(
    .DEPTH(DEPTH), .DATA_W(64), .BITS_W(7), .FLUSH_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .key_config(key_config), .end_stream(end_stream),
    .scon_done(scon_done), .scon_data(scon_data), .scon_bits(scon_bits),
    .out_rcvd(out_rcvd), .out_valid(out_valid), .out_data(out_data),
    .out_bits(out_bits), .out_last(out_last), .dump_comp(dump_comp),
    .stall(stall), .flush_done(flush_done), .overflow(overflow)
  );

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
    logic [6:0]  bits;
    logic        last;
    logic        dump;
    logic        stl;
    logic        fdone;
    logic        ovf;
  } obs_t;

  typedef struct {
    bit          key;
    bit          sd;
    logic [63:0] d;
    logic [6:0]  b;
    bit          rc;
    obs_t        exp;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  obs_t        cur;
  fifo_entry_t mq[$];
  int          m_mode = M_RUN;
  int          m_wait = 0;
  bit          m_ovf  = 0;

  function automatic obs_t sample();
    obs_t o;
    o.valid = out_valid; o.data = out_data; o.bits = out_bits; o.last = out_last;
    o.dump = dump_comp; o.stl = stall; o.fdone = flush_done; o.ovf = overflow;
    return o;
  endfunction

  function automatic obs_t mko(bit v, logic [63:0] d, logic [6:0] b, bit st);
    obs_t o = '0;
    o.valid = v; o.data = d; o.bits = b; o.stl = st;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o = '0;
    if (mq.size() > 0) begin
      o.valid = 1'b1; o.data = mq[0].data; o.bits = mq[0].bits; o.last = mq[0].last;
    end
    o.dump  = (m_mode == M_FLUSH);
    o.stl   = (m_mode != M_RUN) || (mq.size() == DEPTH) || key_config;
    o.fdone = (m_mode == M_DRAIN) && (mq.size() == 0);
    o.ovf   = m_ovf;
    return o;
  endfunction

  task automatic model_update();
    fifo_entry_t e;
    bit was_empty, was_full, do_pop, do_push;
    if (rst) begin
      mq.delete(); m_mode = M_RUN; m_wait = 0; m_ovf = 0;
      return;
    end
    was_empty = (mq.size() == 0);
    was_full  = (mq.size() == DEPTH);
    do_pop    = !was_empty && out_rcvd;
    do_push   = scon_done && !(m_mode == M_WAIT && scon_bits == 0);
    e.data = scon_data; e.bits = scon_bits; e.last = (m_mode == M_WAIT);
    if (do_pop) mq.delete(0);
    if (do_push) begin
      if (was_full && !do_pop) m_ovf = 1;
      else mq.push_back(e);
    end
    case (m_mode)
      M_RUN:   if (key_config) m_mode = M_KEY; else if (end_stream) m_mode = M_FLUSH;
      M_KEY:   if (!key_config) m_mode = M_RUN;
      M_FLUSH: begin m_wait = TMO; m_mode = M_WAIT; end
      M_WAIT:  if (scon_done) m_mode = M_DRAIN;
               else begin m_wait--; if (m_wait == 0) m_mode = M_DRAIN; end
      M_DRAIN: if (was_empty) m_mode = M_RUN;
      default: m_mode = M_RUN;
    endcase
  endtask

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got v=%0b d=%h b=%0d l=%0b dc=%0b st=%0b fd=%0b ov=%0b, expected v=%0b d=%h b=%0d l=%0b dc=%0b st=%0b fd=%0b ov=%0b",
               name, act.valid, act.data, act.bits, act.last, act.dump, act.stl, act.fdone, act.ovf,
               exp.valid, exp.data, exp.bits, exp.last, exp.dump, exp.stl, exp.fdone, exp.ovf);
    end
  endtask

  task automatic chk_int(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive one cycle's inputs, compare the DUT with the model before the edge, then advance the model.
  task automatic step(input bit r, input bit k, input bit es, input bit sd,
                      input logic [63:0] d, input logic [6:0] b, input bit rc);
    rst = r; key_config = k; end_stream = es; scon_done = sd;
    scon_data = d; scon_bits = b; out_rcvd = rc;
    #1;
    cur = sample();
    chk_obs("model", cur, model_obs());
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; key_config = 0; end_stream = 0; scon_done = 0;
    scon_data = '0; scon_bits = '0; out_rcvd = 0;
    repeat (2) begin
      @(posedge clk);
      model_update();
      @(negedge clk);
    end
  endtask

  task automatic idle(input bit rc);
    step(0, 0, 0, 0, 64'h0, 7'd0, rc);
  endtask

  vec_t        tbl[9];
  int          cnt, dumps, found;
  logic [63:0] got[$];

  initial begin
    @(negedge clk);
    do_reset();

    // Directed table: three back-to-back words, ignored out_rcvd, key_config stall.
    tbl[0] = '{key:0, sd:0, d:64'h0,                 b:7'd0,  rc:0, exp:mko(0, 64'h0, 7'd0, 0)};
    tbl[1] = '{key:0, sd:1, d:64'hA1A1_A1A1_A1A1_A1A1, b:7'd64, rc:1, exp:mko(0, 64'h0, 7'd0, 0)};
    tbl[2] = '{key:0, sd:1, d:64'hA2A2_A2A2_A2A2_A2A2, b:7'd64, rc:1, exp:mko(1, 64'hA1A1_A1A1_A1A1_A1A1, 7'd64, 0)};
    tbl[3] = '{key:0, sd:1, d:64'hA3A3_A3A3_A3A3_A3A3, b:7'd64, rc:1, exp:mko(1, 64'hA2A2_A2A2_A2A2_A2A2, 7'd64, 0)};
    tbl[4] = '{key:0, sd:0, d:64'h0,                 b:7'd0,  rc:1, exp:mko(1, 64'hA3A3_A3A3_A3A3_A3A3, 7'd64, 0)};
    tbl[5] = '{key:0, sd:0, d:64'h0,                 b:7'd0,  rc:1, exp:mko(0, 64'h0, 7'd0, 0)};
    tbl[6] = '{key:1, sd:0, d:64'h0,                 b:7'd0,  rc:0, exp:mko(0, 64'h0, 7'd0, 1)};
    tbl[7] = '{key:0, sd:0, d:64'h0,                 b:7'd0,  rc:0, exp:mko(0, 64'h0, 7'd0, 1)};
    tbl[8] = '{key:0, sd:0, d:64'h0,                 b:7'd0,  rc:0, exp:mko(0, 64'h0, 7'd0, 0)};
    for (int i = 0; i < 9; i++) begin
      step(0, tbl[i].key, 0, tbl[i].sd, tbl[i].d, tbl[i].b, tbl[i].rc);
      chk_obs($sformatf("tbl%0d", i), cur, tbl[i].exp);
    end

    // Overflow: five pushes into four entries, then drain.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 64'hB0 + 64'(i), 7'd64, 0);
    idle(0);
    chk_int("ovf_stall", cur.stl, 1);
    chk_int("ovf_flag", cur.ovf, 1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (cur.valid) cnt++;
    end
    chk_int("ovf_drain_count", cnt, 4);
    chk_int("ovf_sticky", cur.ovf, 1);

    // Full buffer with same-cycle push and pop.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 64'hC0 + 64'(i), 7'd64, 0);
    step(0, 0, 0, 1, 64'hC4, 7'd64, 1);
    idle(0);
    chk_int("full_pp_ovf", cur.ovf, 0);
    chk_int("full_pp_stall", cur.stl, 1);
    got.delete();
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (cur.valid) got.push_back(cur.data);
    end
    chk_int("full_pp_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk_int($sformatf("full_pp_order%0d", i), got[i], 64'hC1 + 64'(i));

    // Flush with a 23-bit residual word two cycles after dump_comp.
    do_reset();
    dumps = 0;
    step(0, 0, 1, 0, 64'h0, 7'd0, 0);
    idle(0); dumps += cur.dump;
    idle(0); dumps += cur.dump;
    step(0, 0, 0, 1, 64'hD00D_0000_0000_0023, 7'd23, 0); dumps += cur.dump;
    idle(0); dumps += cur.dump;
    chk_int("flush_last", cur.last, 1);
    chk_int("flush_bits", cur.bits, 23);
    chk_int("flush_fd_early", cur.fdone, 0);
    idle(1);
    idle(0);
    chk_int("flush_done_pulse", cur.fdone, 1);
    idle(0);
    chk_int("flush_done_once", cur.fdone, 0);
    chk_int("flush_dump_count", dumps, 1);

    // Flush timeout with no residual word.
    do_reset();
    step(0, 0, 1, 0, 64'h0, 7'd0, 0);
    found = -1; cnt = 0;
    for (int k = 1; k <= 40 && found < 0; k++) begin
      idle(0);
      if (cur.valid) cnt++;
      if (cur.fdone) found = k;
    end
    chk_int("timeout_fdone_cycle", found, TMO + 2);
    chk_int("timeout_no_word", cnt, 0);

    // key_config with buffered words; end_stream ignored; rst during FWAIT.
    do_reset();
    step(0, 0, 0, 1, 64'hE1, 7'd64, 0);
    step(0, 0, 0, 1, 64'hE2, 7'd64, 0);
    cnt = 0; dumps = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, (i == 2), 0, 64'h0, 7'd0, 1);
      if (cur.valid) cnt++;
      dumps += cur.dump;
      chk_int($sformatf("keycfg_stall%0d", i), cur.stl, 1);
    end
    idle(1); dumps += cur.dump;
    chk_int("keycfg_stall_exit", cur.stl, 1);
    idle(1); dumps += cur.dump;
    chk_int("keycfg_stall_clear", cur.stl, 0);
    chk_int("keycfg_delivered", cnt, 2);
    chk_int("keycfg_no_dump", dumps, 0);
    step(0, 0, 1, 0, 64'h0, 7'd0, 0);
    step(0, 0, 0, 1, 64'hF1, 7'd64, 0);
    idle(0);
    step(1, 0, 0, 0, 64'h0, 7'd0, 0);
    idle(0);
    chk_obs("rst_in_fwait", cur, '0);

    // Randomized traffic against the reference model.
    do_reset();
    begin
      bit k = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 29) == 0) k = !k;
        step(($urandom_range(0, 199) == 0), k, ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 99) < 45), {$urandom, $urandom},
             ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 64)),
             ($urandom_range(0, 99) < 55));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
